id_issue_stage: RTL
===================

Name: id_issue_stage

Overview:
- Decode/issue stage sitting directly upstream of the registered ALU.
- Decodes RV32I OP (0110011) and OP-IMM (0010011) instructions into the team's 6-bit ALU op codes (0–18), selects the two ALU operands, and registers them.
- Tracks the two most recently issued destination registers. Stalls on an age-1 RAW hazard and forwards the ALU result on an age-2 hazard.

Parameters:
XLEN, 32, datapath width.
ALU_OP_W, 6, width of alu_op.
FWD_EN, 1, 1 = forward alu_result at age 2; 0 = stall at both age 1 and age 2.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
instr_in  input  32  instruction word.
instr_valid  input  1  instr_in is valid this cycle.
instr_ready  output  1  combinational; instruction is consumed this edge when instr_valid & instr_ready.
flush  input  1  synchronous kill of in-flight issue state.
rs1_addr  output  5  combinational, instr_in[19:15].
rs2_addr  output  5  combinational, instr_in[24:20].
rs1_data  input  XLEN  register file read data, port 1 (combinational read).
rs2_data  input  XLEN  register file read data, port 2.
alu_result  input  XLEN  ALU data_out (result of the age-2 instruction).
alu_op  output  ALU_OP_W  registered ALU op code.
alu_in_1  output  XLEN  registered operand 1.
alu_in_2  output  XLEN  registered operand 2.
ex_valid  output  1  registered; 1 = real instruction, 0 = bubble.
ex_rd  output  5  registered destination register.
ex_wb_en  output  1  registered; 1 = write back, 0 when rd = x0 or bubble.
illegal_instr  output  1  registered one-cycle pulse for an unsupported encoding.

Behaviour:
- Reset: all registered outputs are 0, and age-1/age-2 tracking is cleared (rd = 0, wb = 0).
- Bubble: ex_valid=0, alu_op=0, alu_in_1=0, alu_in_2=0, ex_rd=0, ex_wb_en=0.
- Issue latency: 1 edge. The ALU result appears at alu_result one edge later.
- The register file is written by the downstream stage on the edge after that, so age ≥ 3 needs no bypass.
- R-type op codes (funct3/funct7):
  - 000/0000000 → 0 (ADD); 000/0100000 → 1 (SUB)
  - 100 → 2 (XOR); 110 → 3 (OR); 111 → 4 (AND)
  - 001 → 5 (SLL); 101/0000000 → 6 (SRL); 101/0100000 → 7 (SRA)
  - 010 → 8 (SLT); 011 → 9 (SLTU)
  - funct7 must be 0000000 except for SUB and SRA.
- I-type op codes:
  - 000 → 10 (ADDI); 100 → 11 (XORI); 110 → 12 (ORI); 111 → 13 (ANDI)
  - 001 → 14 (SLLI); 101/funct7 0000000 → 15 (SRLI); 101/funct7 0100000 → 16 (SRAI)
  - 010 → 17 (SLTI); 011 → 18 (SLTIU)
  - For shifts, funct7 must be 0000000, except SRAI (0100000).
- Operand 2 for I-type:
  - Shifts: zero-extended shamt = instr_in[24:20].
  - Otherwise: sign-extended instr_in[31:20].
- Illegal encoding: any other opcode, funct3/funct7 combination, or an R-type with a bad funct7.
  - A consumed illegal instruction issues a bubble and asserts illegal_instr for 1 cycle.
  - Illegal instructions never stall.
- Source read value:
  - Source x0 always reads 0.
  - Otherwise: if the source matches age-2 rd with wb=1 and FWD_EN=1 → alu_result, else rs*_data.
  - I-type uses rs1 only; rs2 is ignored for hazards.
- Hazard: a used nonzero source matches age-1 rd with wb=1 (or age-2 rd when FWD_EN=0).
  - instr_ready=0 and a bubble is issued.
  - The instruction is re-evaluated next cycle.
  - Both sources matching costs a single stall.
- instr_ready=1 otherwise, including when instr_valid=0. With no valid instruction, a bubble is issued.
- Tracking update every edge: age-2 ← age-1; age-1 ← issued {ex_rd, ex_wb_en}.
- Flush (priority over everything except reset):
  - Next edge: outputs become a bubble, age-1/age-2 clear, illegal_instr=0.
  - instr_ready=1, so the presented instruction is discarded.
- Reset mid-stall: stall state is dropped; the next cycle starts clean.
- Arithmetic: no width growth; all values are XLEN bits.

Test Plan:
- ADDI x1,x0,5 (0x00500093) → next edge: alu_op=10, alu_in_1=0, alu_in_2=5, ex_rd=1, ex_wb_en=1, ex_valid=1.
- ADD x3,x1,x2 issued directly after a write to x1 → instr_ready=0 for 1 cycle with a bubble (ex_valid=0). Next cycle alu_in_1 = alu_result (set 0x1234), and op 0 issues.
- SRAI x5,x6,3 (0x40335293), rs1_data=0x80000000 → alu_op=16, alu_in_2=3. SUB x1,x2,x3 (0x403100B3) → alu_op=1.
- FWD_EN=0, dependent instruction at age 2 → one stall, then operand taken from rs1_data. A dependency on x0 (ADDI x0 then read x0) → no stall, operand 0.
- Opcode 0x00000000 or 0x0000006F → bubble, illegal_instr pulses 1 cycle, instr_ready=1.
- flush during a stall → next edge bubble, instr_ready=1 during the flush. Following independent instruction issues with no stall. reset=1 mid-stream → all outputs 0.

Source files
------------

// File: rtl/id_issue_stage.sv
// Decode/issue stage ahead of the registered ALU: decodes RV32I OP/OP-IMM,
// resolves RAW hazards against the two youngest issued instructions and registers operands.
module id_issue_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 6,
  parameter int FWD_EN   = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instr_in,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                flush,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic [XLEN-1:0]     alu_result,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_in_1,
  output logic [XLEN-1:0]     alu_in_2,
  output logic                ex_valid,
  output logic [4:0]          ex_rd,
  output logic                ex_wb_en,
  output logic                illegal_instr
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]          opcode_s;
  logic [2:0]          funct3_s;
  logic [6:0]          funct7_s;
  logic [4:0]          rs1_s;
  logic [4:0]          rs2_s;
  logic [4:0]          rd_s;
  logic                legal_s;
  logic                is_imm_s;
  logic                is_shift_s;
  logic [ALU_OP_W-1:0] op_s;
  logic [XLEN-1:0]     src1_s;
  logic [XLEN-1:0]     src2_s;
  logic [XLEN-1:0]     opnd2_s;
  logic                hazard_s;
  logic                issue_s;
  logic                illegal_s;

  logic [ALU_OP_W-1:0] alu_op_r;
  logic [XLEN-1:0]     alu_in_1_r;
  logic [XLEN-1:0]     alu_in_2_r;
  logic                ex_valid_r;
  logic [4:0]          ex_rd_r;
  logic                ex_wb_en_r;
  logic                illegal_r;
  logic [4:0]          age2_rd_r;
  logic                age2_wb_r;

  assign opcode_s = instr_in[6:0];
  assign funct3_s = instr_in[14:12];
  assign funct7_s = instr_in[31:25];
  assign rs1_s    = instr_in[19:15];
  assign rs2_s    = instr_in[24:20];
  assign rd_s     = instr_in[11:7];
  assign rs1_addr = rs1_s;
  assign rs2_addr = rs2_s;

  // Age-1 is the instruction now in EX; age-2 is the one whose result is on alu_result.
  function automatic logic src_busy(input logic [4:0] src, input logic [4:0] a1_rd,
                                    input logic a1_wb, input logic [4:0] a2_rd, input logic a2_wb);
    logic busy;
    busy = a1_wb && (a1_rd == src);
    if (FWD_EN == 0) begin
      busy = busy || (a2_wb && (a2_rd == src));
    end else begin
      busy = busy;
    end
    return busy && (src != 5'd0);
  endfunction

  // Instruction decode into ALU op code and legality
  always_comb begin
    legal_s    = 1'b0;
    is_imm_s   = 1'b0;
    is_shift_s = 1'b0;
    op_s       = 6'd0;
    case (opcode_s)
      OPC_OP: begin
        legal_s = (funct7_s == F7_ZERO);
        case (funct3_s)
          3'b000: begin
            legal_s = (funct7_s == F7_ZERO) || (funct7_s == F7_ALT);
            op_s    = (funct7_s == F7_ALT) ? 6'd1 : 6'd0;
          end
          3'b100: op_s = 6'd2;
          3'b110: op_s = 6'd3;
          3'b111: op_s = 6'd4;
          3'b001: op_s = 6'd5;
          3'b101: begin
            legal_s = (funct7_s == F7_ZERO) || (funct7_s == F7_ALT);
            op_s    = (funct7_s == F7_ALT) ? 6'd7 : 6'd6;
          end
          3'b010: op_s = 6'd8;
          3'b011: op_s = 6'd9;
          default: legal_s = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        legal_s  = 1'b1;
        is_imm_s = 1'b1;
        case (funct3_s)
          3'b000: op_s = 6'd10;
          3'b100: op_s = 6'd11;
          3'b110: op_s = 6'd12;
          3'b111: op_s = 6'd13;
          3'b001: begin
            is_shift_s = 1'b1;
            legal_s    = (funct7_s == F7_ZERO);
            op_s       = 6'd14;
          end
          3'b101: begin
            is_shift_s = 1'b1;
            legal_s    = (funct7_s == F7_ZERO) || (funct7_s == F7_ALT);
            op_s       = (funct7_s == F7_ALT) ? 6'd16 : 6'd15;
          end
          3'b010: op_s = 6'd17;
          3'b011: op_s = 6'd18;
          default: legal_s = 1'b0;
        endcase
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Source operand selection with age-2 bypass
  always_comb begin
    src1_s = rs1_data;
    src2_s = rs2_data;
    if (rs1_s == 5'd0) begin
      src1_s = '0;
    end else if ((FWD_EN != 0) && age2_wb_r && (age2_rd_r == rs1_s)) begin
      src1_s = alu_result;
    end else begin
      src1_s = rs1_data;
    end
    if (rs2_s == 5'd0) begin
      src2_s = '0;
    end else if ((FWD_EN != 0) && age2_wb_r && (age2_rd_r == rs2_s)) begin
      src2_s = alu_result;
    end else begin
      src2_s = rs2_data;
    end
  end

  // Operand 2: shamt, sign-extended immediate or rs2
  always_comb begin
    opnd2_s = src2_s;
    if (is_imm_s && is_shift_s) begin
      opnd2_s = {{(XLEN-5){1'b0}}, instr_in[24:20]};
    end else if (is_imm_s) begin
      opnd2_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    end else begin
      opnd2_s = src2_s;
    end
  end

  // Hazard detection and issue handshake; illegal words never stall
  always_comb begin
    hazard_s = instr_valid && legal_s &&
               (src_busy(rs1_s, ex_rd_r, ex_wb_en_r, age2_rd_r, age2_wb_r) ||
                (!is_imm_s && src_busy(rs2_s, ex_rd_r, ex_wb_en_r, age2_rd_r, age2_wb_r)));
    instr_ready = flush || !hazard_s;
    issue_s     = instr_valid && legal_s && !hazard_s && !flush;
    illegal_s   = instr_valid && !legal_s && !flush;
  end

  // EX register and age tracking; reset and flush both return to a clean bubble
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      alu_op_r   <= '0;
      alu_in_1_r <= '0;
      alu_in_2_r <= '0;
      ex_valid_r <= 1'b0;
      ex_rd_r    <= 5'd0;
      ex_wb_en_r <= 1'b0;
      illegal_r  <= 1'b0;
      age2_rd_r  <= 5'd0;
      age2_wb_r  <= 1'b0;
    end else begin
      alu_op_r   <= issue_s ? op_s : '0;
      alu_in_1_r <= issue_s ? src1_s : '0;
      alu_in_2_r <= issue_s ? opnd2_s : '0;
      ex_valid_r <= issue_s;
      ex_rd_r    <= issue_s ? rd_s : 5'd0;
      ex_wb_en_r <= issue_s && (rd_s != 5'd0);
      illegal_r  <= illegal_s;
      age2_rd_r  <= ex_rd_r;
      age2_wb_r  <= ex_wb_en_r;
    end
  end

  assign alu_op        = alu_op_r;
  assign alu_in_1      = alu_in_1_r;
  assign alu_in_2      = alu_in_2_r;
  assign ex_valid      = ex_valid_r;
  assign ex_rd         = ex_rd_r;
  assign ex_wb_en      = ex_wb_en_r;
  assign illegal_instr = illegal_r;

endmodule
